// File: rtl/wb_master_bridge_if.sv
// Request/response handshake and Wishbone classic bus bundle for wb_master_bridge.
// master: bridge side (takes req_*, drives rsp_* and wb_*); slave: requester + Wishbone slave side.
interface wb_master_bridge_if #(
  parameter int addr_width   = 32,
  parameter int data_width   = 32,
  parameter int strobe_width = data_width / 8
);
  logic                    req_valid;
  logic                    req_ready;
  logic [addr_width-1:0]   req_addr;
  logic [data_width-1:0]   req_wdata;
  logic                    req_we;
  logic [strobe_width-1:0] req_sel;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [data_width-1:0]   rsp_rdata;
  logic                    rsp_err;
  logic [addr_width-1:0]   wb_adr;
  logic [data_width-1:0]   wb_datwr;
  logic [data_width-1:0]   wb_datrd;
  logic                    wb_we;
  logic                    wb_stb;
  logic                    wb_ack;
  logic                    wb_cyc;
  logic [strobe_width-1:0] wb_sel;

  modport master (
    input  req_valid, req_addr, req_wdata, req_we, req_sel,
    input  rsp_ready, wb_datrd, wb_ack,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output wb_adr, wb_datwr, wb_we, wb_stb, wb_cyc, wb_sel
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_we, req_sel,
    output rsp_ready, wb_datrd, wb_ack,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  wb_adr, wb_datwr, wb_we, wb_stb, wb_cyc, wb_sel
  );
endinterface

// File: rtl/wb_master_bridge.sv
// Single-outstanding valid/ready to Wishbone classic master bridge with ack timeout.
// Ports: clock, reset (sync, active-low), bus (wb_master_bridge_if.master).
module wb_master_bridge #(
  parameter int addr_width     = 32,
  parameter int data_width     = 32,
  parameter int strobe_width   = data_width / 8,
  parameter int timeout_cycles = 255
) (
  input  logic               clock,
  input  logic               reset,
  wb_master_bridge_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(timeout_cycles - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic [7:0]              r_cnt;
  logic                    r_cyc;
  logic                    r_we;
  logic [addr_width-1:0]   r_adr;
  logic [data_width-1:0]   r_datwr;
  logic [strobe_width-1:0] r_sel;
  logic [data_width-1:0]   r_rdata;
  logic                    r_err;
  logic                    w_tout;

  // ack wins over a same-cycle timeout
  assign w_tout = (r_cnt == TO_LAST) && !bus.wb_ack;

  always_ff @(posedge clock) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.req_valid) w_next = BUS;
      BUS:     if (bus.wb_ack || w_tout) w_next = RESP;
      RESP:    if (bus.rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = reset && (r_state == IDLE);
    bus.rsp_valid = reset && (r_state == RESP);
    bus.rsp_rdata = r_rdata;
    bus.rsp_err   = r_err;
    bus.wb_adr    = r_adr;
    bus.wb_datwr  = r_datwr;
    bus.wb_we     = r_we;
    bus.wb_sel    = r_sel;
    bus.wb_cyc    = r_cyc;
    bus.wb_stb    = r_cyc;
  end

  // wb_ack is only looked at in BUS, so a trailing ack is dropped
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_datwr <= '0;
      r_sel   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_adr   <= bus.req_addr;
            r_datwr <= bus.req_wdata;
            r_we    <= bus.req_we;
            r_sel   <= bus.req_sel;
            r_cyc   <= 1'b1;
            r_cnt   <= '0;
          end
        end
        BUS: begin
          if (bus.wb_ack) begin
            if (!r_we) r_rdata <= bus.wb_datrd;
            r_err <= 1'b0;
            r_cyc <= 1'b0;
          end else if (w_tout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_cyc   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge with a small byte-lane SRAM Wishbone slave.
// Slave acks one edge after stb and keeps ack for one trailing cycle.
module tb_wb_master_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  wb_master_bridge_if #(.addr_width(AW), .data_width(DW), .strobe_width(SW)) bus ();

  wb_master_bridge #(
    .addr_width(AW), .data_width(DW),
    .strobe_width(SW), .timeout_cycles(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  logic [31:0] mem [0:15];
  logic        ack_en = 1'b1;
  logic        r_ack  = 1'b0;
  int          cyc_no = 0;

  initial for (int i = 0; i < 16; i++) mem[i] = 32'h0;

  always @(posedge clock) begin
    cyc_no <= cyc_no + 1;
    if (bus.wb_cyc && bus.wb_stb && bus.wb_we && ack_en && !r_ack)
      for (int b = 0; b < 4; b++)
        if (bus.wb_sel[b])
          mem[bus.wb_adr[5:2]][8*b +: 8] <= bus.wb_datwr[8*b +: 8];
    r_ack <= bus.wb_cyc && bus.wb_stb && ack_en;
  end

  assign bus.wb_ack   = r_ack;
  assign bus.wb_datrd = mem[bus.wb_adr[5:2]];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        ack_en;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_cyc;
    int          exp_lat;
  } vec_t;

  vec_t tbl [10];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // called at a negedge with the bridge idle; returns at the negedge after consume
  task automatic run_txn(input vec_t v, output int acc);
    int k;
    int lat;
    int ncyc;
    ack_en        = v.ack_en;
    bus.req_we    = v.we;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.req_sel   = v.sel;
    bus.req_valid = 1'b1;
    k = 0;
    while (!bus.req_ready && k < 20) begin
      @(negedge clock);
      k++;
    end
    chk("req_ready", {31'b0, bus.req_ready}, 32'd1);
    acc = cyc_no;
    @(negedge clock);
    bus.req_valid = 1'b0;
    chk("wb_adr", bus.wb_adr, v.addr);
    chk("wb_we", {31'b0, bus.wb_we}, {31'b0, v.we});
    chk("wb_sel", {28'b0, bus.wb_sel}, {28'b0, v.sel});
    chk("wb_datwr", bus.wb_datwr, v.wdata);
    lat  = 1;
    ncyc = 0;
    while (!bus.rsp_valid && lat < 20) begin
      if (bus.wb_cyc) ncyc++;
      if (bus.wb_stb !== bus.wb_cyc) chk("stb_eq_cyc", {31'b0, bus.wb_stb}, {31'b0, bus.wb_cyc});
      @(negedge clock);
      lat++;
    end
    chk("rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
    chk("latency", lat, v.exp_lat);
    chk("cyc_cycles", ncyc, v.exp_cyc);
    chk("rsp_rdata", bus.rsp_rdata, v.exp_rdata);
    chk("rsp_err", {31'b0, bus.rsp_err}, {31'b0, v.exp_err});
    chk("resp_cyc", {31'b0, bus.wb_cyc}, 32'd0);
    chk("resp_ready", {31'b0, bus.req_ready}, 32'd0);
    @(negedge clock);
    chk("consumed", {31'b0, bus.rsp_valid}, 32'd0);
    chk("idle_ready", {31'b0, bus.req_ready}, 32'd1);
  endtask

  task automatic wait_rsp(input string name);
    int k;
    k = 0;
    while (!bus.rsp_valid && k < 20) begin
      @(negedge clock);
      k++;
    end
    chk(name, {31'b0, bus.rsp_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int a0, a1, a2;
    tbl[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0,        1'b0, 2, 3};
    tbl[1] = '{1'b0, 32'h10, 32'h0,        4'hF, 1'b1, 32'hDEADBEEF, 1'b0, 2, 3};
    tbl[2] = '{1'b1, 32'h10, 32'h000000AA, 4'h1, 1'b1, 32'hDEADBEEF, 1'b0, 2, 3};
    tbl[3] = '{1'b0, 32'h10, 32'h0,        4'hF, 1'b1, 32'hDEADBEAA, 1'b0, 2, 3};
    tbl[4] = '{1'b1, 32'h14, 32'h12345678, 4'hC, 1'b1, 32'hDEADBEAA, 1'b0, 2, 3};
    tbl[5] = '{1'b0, 32'h14, 32'h0,        4'hF, 1'b1, 32'h12340000, 1'b0, 2, 3};
    tbl[6] = '{1'b0, 32'h20, 32'h0,        4'hF, 1'b0, 32'h0,        1'b1, 4, 5};
    tbl[7] = '{1'b0, 32'h10, 32'h0,        4'hF, 1'b1, 32'hDEADBEAA, 1'b0, 2, 3};
    tbl[8] = '{1'b1, 32'h18, 32'h55667788, 4'hF, 1'b0, 32'h0,        1'b1, 4, 5};
    tbl[9] = '{1'b0, 32'h18, 32'h0,        4'hF, 1'b1, 32'h0,        1'b0, 2, 3};

    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_we    = 1'b0;
    bus.req_sel   = '0;
    bus.rsp_ready = 1'b1;

    repeat (3) @(negedge clock);
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_cyc", {31'b0, bus.wb_cyc}, 32'd0);
    chk("rst_stb", {31'b0, bus.wb_stb}, 32'd0);
    chk("rst_we", {31'b0, bus.wb_we}, 32'd0);
    chk("rst_adr", bus.wb_adr, 32'd0);
    chk("rst_datwr", bus.wb_datwr, 32'd0);
    chk("rst_sel", {28'b0, bus.wb_sel}, 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_err", {31'b0, bus.rsp_err}, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 10; i++) run_txn(tbl[i], acc);

    // response held while consumer stalls
    ack_en        = 1'b1;
    bus.rsp_ready = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h10;
    bus.req_valid = 1'b1;
    @(negedge clock);
    bus.req_valid = 1'b0;
    wait_rsp("stall_rsp");
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'b0, bus.rsp_valid}, 32'd1);
      chk("stall_rdata", bus.rsp_rdata, 32'hDEADBEAA);
      chk("stall_err", {31'b0, bus.rsp_err}, 32'd0);
      chk("stall_ready", {31'b0, bus.req_ready}, 32'd0);
      chk("stall_cyc", {31'b0, bus.wb_cyc}, 32'd0);
      @(negedge clock);
    end
    bus.rsp_ready = 1'b1;
    bus.req_addr  = 32'h14;
    bus.req_valid = 1'b1;
    @(negedge clock);
    chk("rel_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rel_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rel_no_accept", {31'b0, bus.wb_cyc}, 32'd0);
    @(negedge clock);
    bus.req_valid = 1'b0;
    chk("rel_accept", {31'b0, bus.wb_cyc}, 32'd1);
    chk("rel_adr", bus.wb_adr, 32'h14);
    wait_rsp("rel_rsp");
    chk("rel_rdata", bus.rsp_rdata, 32'h12340000);
    @(negedge clock);

    // reset in the middle of a bus cycle
    bus.req_addr  = 32'h10;
    bus.req_valid = 1'b1;
    @(negedge clock);
    bus.req_valid = 1'b0;
    chk("mid_cyc_on", {31'b0, bus.wb_cyc}, 32'd1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_cyc_off", {31'b0, bus.wb_cyc}, 32'd0);
    chk("mid_stb_off", {31'b0, bus.wb_stb}, 32'd0);
    chk("mid_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
    chk("mid_no_ready", {31'b0, bus.req_ready}, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("post_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
      chk("post_cyc", {31'b0, bus.wb_cyc}, 32'd0);
    end
    chk("post_rdata", bus.rsp_rdata, 32'd0);
    run_txn('{1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 32'hDEADBEAA, 1'b0, 2, 3}, acc);

    // back-to-back: one accept every 4 cycles, trailing acks ignored
    run_txn('{1'b1, 32'h1C, 32'hCAFEF00D, 4'hF, 1'b1, 32'hDEADBEAA, 1'b0, 2, 3}, a0);
    run_txn('{1'b0, 32'h1C, 32'h0, 4'hF, 1'b1, 32'hCAFEF00D, 1'b0, 2, 3}, a1);
    run_txn('{1'b0, 32'h14, 32'h0, 4'hF, 1'b1, 32'h12340000, 1'b0, 2, 3}, a2);
    chk("b2b_gap0", a1 - a0, 32'd4);
    chk("b2b_gap1", a2 - a1, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
